// File: rtl/wl_seq_ctrl.sv
// Word-line drive sequencer: loads DAC lane codes, waits for settling, then pulses one
// write strobe per address for broadcast pre-op, single-address and address-sweep commands.
module wl_seq_ctrl #(
   parameter int SETTLE_CYC = 4,
   parameter int N_LANE     = 8,
   parameter int CODE_W     = 8,
   parameter int ADDR_W     = 5
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           cmd_valid,
   output logic                           cmd_ready,
   input  logic [1:0]                     cmd_op,
   input  logic [ADDR_W-1:0]              cmd_addr,
   input  logic [ADDR_W-1:0]              cmd_addr_end,
   input  logic [CODE_W-1:0]              cmd_code,
   input  logic [CODE_W-1:0]              cmd_step,
   input  logic                           abort,
   output logic [N_LANE-1:0][CODE_W-1:0]  dac_code,
   output logic [ADDR_W-1:0]              wl_addr,
   output logic                           wl_addr_en,
   output logic                           wl_pre_op_en,
   output logic                           busy,
   output logic                           done,
   output logic                           done_err,
   output logic                           done_abort
);

   localparam int LANE_W = $clog2(N_LANE);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_STROBE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      OP_PRE    = 2'b00,
      OP_SINGLE = 2'b01,
      OP_SWEEP  = 2'b10,
      OP_ILL    = 2'b11
   } op_t;

   // The settle counter counts down to zero, so it is loaded with one less than the dwell.
   localparam int unsigned SETTLE_LOAD = (SETTLE_CYC == 0) ? 0 : SETTLE_CYC - 1;
   localparam logic [7:0]  CNT_LOAD    = 8'(SETTLE_LOAD);
   localparam state_t      FIRST_STATE = (SETTLE_CYC == 0) ? S_STROBE : S_SETTLE;

   state_t                          state_q, state_d;
   op_t                             op_q, op_d;
   logic [ADDR_W-1:0]               addr_end_q, addr_end_d;
   logic [CODE_W-1:0]               code_q, code_d;
   logic [CODE_W-1:0]               step_q, step_d;
   logic [7:0]                      cnt_q, cnt_d;
   logic [N_LANE-1:0][CODE_W-1:0]   dac_q, dac_d;
   logic [ADDR_W-1:0]               wl_addr_q, wl_addr_d;
   logic                            addr_en_q, addr_en_d;
   logic                            pre_op_en_q, pre_op_en_d;
   logic                            cmd_ready_q, cmd_ready_d;
   logic                            done_q, done_d;
   logic                            done_err_q, done_err_d;
   logic                            done_abort_q, done_abort_d;

   logic [CODE_W:0]                 code_sum;
   logic [CODE_W-1:0]               code_next;
   logic [ADDR_W-1:0]               addr_next;

   // Running code saturates at full scale; the sequence is monotonic so this equals min(base+k*step, max).
   always_comb begin
      code_sum  = {1'b0, code_q} + {1'b0, step_q};
      code_next = code_sum[CODE_W] ? {CODE_W{1'b1}} : code_sum[CODE_W-1:0];
      addr_next = wl_addr_q + 1'b1;
   end

   // NOTE: every _d variable gets its hold value first so no path through the case infers a latch.
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      addr_end_d   = addr_end_q;
      code_d       = code_q;
      step_d       = step_q;
      cnt_d        = cnt_q;
      dac_d        = dac_q;
      wl_addr_d    = wl_addr_q;
      done_err_d   = 1'b0;
      done_abort_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               op_d       = op_t'(cmd_op);
               addr_end_d = cmd_addr_end;
               code_d     = cmd_code;
               step_d     = cmd_step;
               wl_addr_d  = cmd_addr;
               cnt_d      = CNT_LOAD;
               case (op_t'(cmd_op))
                  OP_PRE: begin
                     for (int i = 0; i < N_LANE; i++) dac_d[i] = cmd_code;
                     state_d = FIRST_STATE;
                  end
                  OP_SINGLE, OP_SWEEP: begin
                     dac_d[cmd_addr[LANE_W-1:0]] = cmd_code;
                     state_d = FIRST_STATE;
                  end
                  default: begin
                     state_d    = S_DONE;
                     done_err_d = 1'b1;
                  end
               endcase
            end
         end
         S_SETTLE: begin
            if (cnt_q == 8'd0) state_d = S_STROBE;
            else               cnt_d   = cnt_q - 8'd1;
         end
         S_STROBE: begin
            if (op_q == OP_SWEEP && wl_addr_q != addr_end_q) begin
               wl_addr_d                    = addr_next;
               code_d                       = code_next;
               dac_d[addr_next[LANE_W-1:0]] = code_next;
               cnt_d                        = CNT_LOAD;
               state_d                      = FIRST_STATE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Abort freezes the datapath; a completed command sitting in DONE is not re-reported.
      if (abort && (state_q == S_SETTLE || state_q == S_STROBE)) begin
         state_d      = S_DONE;
         wl_addr_d    = wl_addr_q;
         dac_d        = dac_q;
         code_d       = code_q;
         cnt_d        = cnt_q;
         done_abort_d = 1'b1;
      end

      addr_en_d   = (state_d == S_STROBE) && (op_d != OP_PRE);
      pre_op_en_d = (state_d == S_STROBE) && (op_d == OP_PRE);
      cmd_ready_d = (state_d == S_IDLE);
      done_d      = (state_d == S_DONE);
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         op_q         <= OP_PRE;
         addr_end_q   <= '0;
         code_q       <= '0;
         step_q       <= '0;
         cnt_q        <= '0;
         // NOTE: the lane-code bank drives the DAC directly, so it is reset rather than left unknown.
         dac_q        <= '0;
         wl_addr_q    <= '0;
         addr_en_q    <= 1'b0;
         pre_op_en_q  <= 1'b0;
         cmd_ready_q  <= 1'b1;
         done_q       <= 1'b0;
         done_err_q   <= 1'b0;
         done_abort_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         addr_end_q   <= addr_end_d;
         code_q       <= code_d;
         step_q       <= step_d;
         cnt_q        <= cnt_d;
         dac_q        <= dac_d;
         wl_addr_q    <= wl_addr_d;
         addr_en_q    <= addr_en_d;
         pre_op_en_q  <= pre_op_en_d;
         cmd_ready_q  <= cmd_ready_d;
         done_q       <= done_d;
         done_err_q   <= done_err_d;
         done_abort_q <= done_abort_d;
      end
   end

   assign cmd_ready    = cmd_ready_q;
   assign busy         = ~cmd_ready_q;
   assign dac_code     = dac_q;
   assign wl_addr      = wl_addr_q;
   assign wl_addr_en   = addr_en_q;
   assign wl_pre_op_en = pre_op_en_q;
   assign done         = done_q;
   assign done_err     = done_err_q;
   assign done_abort   = done_abort_q;

endmodule

// File: tb/tb_wl_seq_ctrl.sv
// Directed bench for wl_seq_ctrl: one instance with a 4-cycle settle and one with no settle,
// driven from a command table plus hand sequences for abort, held requests and async reset.
module tb_wl_seq_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic cmd_valid = 1'b0;
   logic [1:0] cmd_op = 2'b00;
   logic [4:0] cmd_addr = '0, cmd_addr_end = '0;
   logic [7:0] cmd_code = '0, cmd_step = '0;
   logic abort = 1'b0;
   logic use0 = 1'b0;

   always #5 clk = ~clk;

   logic [7:0][7:0] d4_dac, d0_dac, o_dac;
   logic [4:0] d4_addr, d0_addr, o_addr;
   logic d4_rdy, d4_en, d4_pre, d4_busy, d4_done, d4_err, d4_abt;
   logic d0_rdy, d0_en, d0_pre, d0_busy, d0_done, d0_err, d0_abt;
   logic o_rdy, o_en, o_pre, o_busy, o_done, o_err, o_abt;

   wl_seq_ctrl #(.SETTLE_CYC(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(d4_rdy), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_addr_end(cmd_addr_end), .cmd_code(cmd_code), .cmd_step(cmd_step),
      .abort(abort), .dac_code(d4_dac), .wl_addr(d4_addr), .wl_addr_en(d4_en),
      .wl_pre_op_en(d4_pre), .busy(d4_busy), .done(d4_done), .done_err(d4_err), .done_abort(d4_abt));

   wl_seq_ctrl #(.SETTLE_CYC(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(d0_rdy), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_addr_end(cmd_addr_end), .cmd_code(cmd_code), .cmd_step(cmd_step),
      .abort(abort), .dac_code(d0_dac), .wl_addr(d0_addr), .wl_addr_en(d0_en),
      .wl_pre_op_en(d0_pre), .busy(d0_busy), .done(d0_done), .done_err(d0_err), .done_abort(d0_abt));

   assign o_dac  = use0 ? d0_dac  : d4_dac;
   assign o_addr = use0 ? d0_addr : d4_addr;
   assign o_rdy  = use0 ? d0_rdy  : d4_rdy;
   assign o_en   = use0 ? d0_en   : d4_en;
   assign o_pre  = use0 ? d0_pre  : d4_pre;
   assign o_busy = use0 ? d0_busy : d4_busy;
   assign o_done = use0 ? d0_done : d4_done;
   assign o_err  = use0 ? d0_err  : d4_err;
   assign o_abt  = use0 ? d0_abt  : d4_abt;

   typedef struct {
      logic       use0;
      logic [1:0] op;
      logic [4:0] addr;
      logic [4:0] addr_end;
      logic [7:0] code;
      logic [7:0] step;
      logic       err;
      int         n;
      int         done_cyc;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0][7:0] lanes_m = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] sat_code(input logic [7:0] base, input int k, input logic [7:0] step);
      int s;
      s = int'(base) + k * int'(step);
      return (s > 255) ? 8'hFF : 8'(s);
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      cmd_valid = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      lanes_m = '0;
      @(negedge clk);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_ready"}, o_rdy, 1'b1);
      check({tag, "_busy"}, o_busy, 1'b0);
      check({tag, "_strobes"}, {o_en, o_pre}, 2'b00);
      check({tag, "_done_flags"}, {o_done, o_err, o_abt}, 3'b000);
      check({tag, "_wl_addr"}, o_addr, 5'd0);
      check({tag, "_dac"}, o_dac, 64'd0);
   endtask

   // Called at a negedge in an idle cycle; returns at the negedge of cycle E0+1.
   task automatic issue(input logic [1:0] op, input logic [4:0] a, input logic [4:0] e,
                        input logic [7:0] code, input logic [7:0] step);
      check("accept_ready", o_rdy, 1'b1);
      cmd_valid = 1'b1;
      cmd_op = op;
      cmd_addr = a;
      cmd_addr_end = e;
      cmd_code = code;
      cmd_step = step;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int p, j;
      logic strobe_exp;
      logic [4:0] a;
      logic [7:0] ec;
      p = v.use0 ? 1 : 5;
      issue(v.op, v.addr, v.addr_end, v.code, v.step);
      for (int k = 1; k <= v.done_cyc + 1; k++) begin
         strobe_exp = !v.err && (k % p == 0) && (k / p >= 1) && (k / p <= v.n);
         check("wl_addr_en", o_en, strobe_exp && v.op != 2'b00);
         check("wl_pre_op_en", o_pre, strobe_exp && v.op == 2'b00);
         check("done", o_done, k == v.done_cyc);
         if (strobe_exp) begin
            j = k / p - 1;
            a = v.addr + 5'(j);
            ec = sat_code(v.code, j, v.step);
            check("strobe_wl_addr", o_addr, a);
            if (v.op == 2'b00) begin
               lanes_m = {8{ec}};
               check("pre_op_lanes", o_dac, lanes_m);
            end else begin
               lanes_m[a[2:0]] = ec;
               check("strobe_lane_code", o_dac[a[2:0]], ec);
            end
         end
         if (k == v.done_cyc) begin
            check("done_err", o_err, v.err);
            check("done_abort", o_abt, 1'b0);
            check("done_all_lanes", o_dac, lanes_m);
         end
         if (k == v.done_cyc + 1) check("ready_after_done", o_rdy, 1'b1);
         else @(negedge clk);
      end
   endtask

   vec_t tbl[9];

   initial begin
      int strobes;
      int bad_addr;

      tbl[0] = '{1'b0, 2'b00, 5'd0,  5'd0,  8'h80, 8'h00, 1'b0, 1,  6};
      tbl[1] = '{1'b0, 2'b01, 5'd13, 5'd0,  8'h3C, 8'h00, 1'b0, 1,  6};
      tbl[2] = '{1'b0, 2'b10, 5'd30, 5'd1,  8'hF0, 8'h08, 1'b0, 4,  21};
      tbl[3] = '{1'b0, 2'b10, 5'd5,  5'd5,  8'h11, 8'h22, 1'b0, 1,  6};
      tbl[4] = '{1'b0, 2'b11, 5'd9,  5'd12, 8'hAA, 8'h01, 1'b1, 0,  1};
      tbl[5] = '{1'b0, 2'b10, 5'd3,  5'd2,  8'h00, 8'h09, 1'b0, 32, 161};
      tbl[6] = '{1'b1, 2'b10, 5'd0,  5'd7,  8'h10, 8'h01, 1'b0, 8,  9};
      tbl[7] = '{1'b1, 2'b00, 5'd4,  5'd0,  8'h5A, 8'h00, 1'b0, 1,  2};
      tbl[8] = '{1'b1, 2'b11, 5'd1,  5'd1,  8'h77, 8'h00, 1'b1, 0,  1};

      do_reset();
      check_reset_vals("reset");

      for (int i = 0; i < 9; i++) begin
         if (i > 0 && tbl[i].use0 != tbl[i-1].use0) begin
            use0 = tbl[i].use0;
            do_reset();
            check_reset_vals("reset0");
         end
         run_vec(tbl[i]);
      end

      // Abort during the second settle of an 8->15 sweep.
      use0 = 1'b0;
      do_reset();
      issue(2'b10, 5'd8, 5'd15, 8'h20, 8'h01);
      strobes = 0;
      for (int k = 1; k <= 7; k++) begin
         strobes += int'(o_en);
         if (k < 7) @(negedge clk);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_strobe_count", 32'(strobes), 32'd1);
      check("abort_no_strobe", {o_en, o_pre}, 2'b00);
      check("abort_done_flags", {o_done, o_err, o_abt}, 3'b101);
      check("abort_wl_addr_held", o_addr, 5'd9);
      check("abort_lane1_held", o_dac[1], 8'h21);
      @(negedge clk);
      check("abort_ready_back", o_rdy, 1'b1);
      check("abort_done_pulse", o_done, 1'b0);
      lanes_m[0] = 8'h20;
      lanes_m[1] = 8'h21;
      run_vec('{1'b0, 2'b01, 5'd2, 5'd0, 8'h55, 8'h00, 1'b0, 1, 6});

      // Abort while idle has no effect.
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("idle_abort_ready", o_rdy, 1'b1);
      check("idle_abort_done", {o_done, o_abt}, 2'b00);

      // cmd_valid held through a whole command with changing fields.
      cmd_valid = 1'b1;
      cmd_op = 2'b01;
      cmd_addr = 5'd3;
      cmd_code = 8'h44;
      @(negedge clk);
      cmd_addr = 5'd4;
      cmd_code = 8'h99;
      strobes = 0;
      bad_addr = 0;
      for (int k = 1; k <= 10; k++) begin
         if (o_en) begin
            strobes++;
            if (o_addr != 5'd3) bad_addr++;
         end
         if (k == 6) begin
            check("held_done", o_done, 1'b1);
            cmd_valid = 1'b0;
         end
         if (k > 6) check("held_idle_ready", o_rdy, 1'b1);
         @(negedge clk);
      end
      check("held_strobe_count", 32'(strobes), 32'd1);
      check("held_strobe_addr", 32'(bad_addr), 32'd0);
      check("held_lane3", o_dac[3], 8'h44);
      check("held_lane4_untouched", o_dac[4], 8'h00);

      // Asynchronous reset in the middle of a sweep.
      issue(2'b10, 5'd0, 5'd31, 8'h01, 8'h01);
      repeat (11) @(negedge clk);
      check("midsweep_busy", o_busy, 1'b1);
      #2 rst_n = 1'b0;
      #1 check_reset_vals("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      lanes_m = '0;
      strobes = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         strobes += int'(o_done) + int'(o_en);
      end
      check("post_reset_quiet", 32'(strobes), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
